// File: rtl/cutie_params_pkg.sv
// Shared CUTIE datapath constants and types used by the layer sequencer.
package cutie_params;

    localparam int NUM_LAYERS          = 8;
    localparam int NUMACTMEMBANKSETS   = 3;
    localparam int WEIGHT_STAGGER      = 2;
    localparam int K                   = 3;

    localparam int WEIGHT_LAYER_STRIDE = WEIGHT_STAGGER * K * K;
    localparam int TCN_BANKSET         = NUMACTMEMBANKSETS - 1;
    localparam int BANKSETW            = $clog2(NUMACTMEMBANKSETS);

    typedef logic [BANKSETW-1:0] bankset_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN,
        FINISH
    } seq_state_e;

endpackage

// File: rtl/cutie_bankset_alloc.sv
// Picks the next layer's activation bank sets: read what was just written,
// write either the TCN set or the ping-pong set opposite the new read set.
module cutie_bankset_alloc
    import cutie_params::*;
(
    input  bankset_t cur_wr,
    input  logic     tcn,
    output bankset_t next_rd,
    output bankset_t next_wr
);

    always_comb begin
        next_rd = cur_wr;
        if (tcn)
            next_wr = bankset_t'(TCN_BANKSET);
        else if (cur_wr == bankset_t'(1))
            next_wr = bankset_t'(0);
        else
            next_wr = bankset_t'(1);
    end

endmodule

// File: rtl/cutie_layer_sequencer.sv
// Walks one multi-layer inference: issues a descriptor per layer, waits for
// the datapath's done pulse, and signals completion of the whole execution.
module cutie_layer_sequencer
    import cutie_params::*;
#(
    parameter int N_LAYERS = NUM_LAYERS,
    parameter int CW       = $clog2(N_LAYERS + 1),
    parameter int IW       = $clog2(N_LAYERS),
    parameter int WBASEW   = $clog2(N_LAYERS * WEIGHT_LAYER_STRIDE)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [CW-1:0]       num_layers_i,
    input  logic [N_LAYERS-1:0] tcn_mask_i,
    output logic                layer_valid_o,
    input  logic                layer_ready_i,
    output logic [IW-1:0]       layer_idx_o,
    output logic [WBASEW-1:0]   weight_base_o,
    output logic [BANKSETW-1:0] rd_bankset_o,
    output logic [BANKSETW-1:0] wr_bankset_o,
    input  logic                layer_done_i,
    output logic                busy_o,
    output logic                done_o
);

    seq_state_e          state_q, state_d;
    logic [CW-1:0]       num_layers_q;
    logic [N_LAYERS-1:0] tcn_mask_q;
    logic                cfg_load;

    logic [IW-1:0]       idx_q, idx_d, idx_inc;
    logic [WBASEW-1:0]   base_q, base_d;
    bankset_t            rd_q, rd_d, wr_q, wr_d;
    bankset_t            alloc_rd, alloc_wr;

    logic [CW-1:0]       num_clamped;
    logic                last_layer;

    assign num_clamped = (num_layers_i > CW'(N_LAYERS)) ? CW'(N_LAYERS) : num_layers_i;
    assign idx_inc     = idx_q + IW'(1);
    assign last_layer  = (CW'(idx_q) + CW'(1)) == num_layers_q;

    cutie_bankset_alloc u_alloc (
        .cur_wr  (wr_q),
        .tcn     (tcn_mask_q[idx_inc]),
        .next_rd (alloc_rd),
        .next_wr (alloc_wr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        base_d   = base_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        cfg_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cfg_load = 1'b1;
                    if (num_clamped == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = '0;
                        base_d  = '0;
                        rd_d    = bankset_t'(0);
                        wr_d    = tcn_mask_i[0] ? bankset_t'(TCN_BANKSET) : bankset_t'(1);
                    end
                end
            end
            ISSUE: begin
                if (layer_ready_i) state_d = RUN;
            end
            RUN: begin
                if (layer_done_i) begin
                    if (last_layer) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = idx_inc;
                        // Running sum keeps the stride multiply out of the datapath.
                        base_d  = base_q + WBASEW'(WEIGHT_LAYER_STRIDE);
                        rd_d    = alloc_rd;
                        wr_d    = alloc_wr;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            num_layers_q <= '0;
            tcn_mask_q   <= '0;
            idx_q        <= '0;
            base_q       <= '0;
            rd_q         <= bankset_t'(0);
            wr_q         <= bankset_t'(1);
        end else begin
            if (cfg_load) begin
                num_layers_q <= num_clamped;
                tcn_mask_q   <= tcn_mask_i;
            end
            idx_q  <= idx_d;
            base_q <= base_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
        end
    end

    assign layer_valid_o = (state_q == ISSUE);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == FINISH);
    assign layer_idx_o   = idx_q;
    assign weight_base_o = base_q;
    assign rd_bankset_o  = rd_q;
    assign wr_bankset_o  = wr_q;

endmodule

// File: tb/tb_cutie_layer_sequencer.sv
// Directed bench for cutie_layer_sequencer: hand-computed descriptors per layer.
module tb_cutie_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] num_layers;
    logic [7:0] tcn_mask;
    logic       layer_valid;
    logic       layer_ready;
    logic [2:0] layer_idx;
    logic [7:0] weight_base;
    logic [1:0] rd_bankset;
    logic [1:0] wr_bankset;
    logic       layer_done;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int n_done = 0;
    int n_hs   = 0;

    always #5 clk = ~clk;

    cutie_layer_sequencer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .num_layers_i  (num_layers),
        .tcn_mask_i    (tcn_mask),
        .layer_valid_o (layer_valid),
        .layer_ready_i (layer_ready),
        .layer_idx_o   (layer_idx),
        .weight_base_o (weight_base),
        .rd_bankset_o  (rd_bankset),
        .wr_bankset_o  (wr_bankset),
        .layer_done_i  (layer_done),
        .busy_o        (busy),
        .done_o        (done)
    );

    always @(posedge clk) begin
        if (done === 1'b1) n_done++;
        if (layer_valid === 1'b1 && layer_ready === 1'b1) n_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Waits for the descriptor, checks it, lets it handshake, then runs the layer 5 cycles.
    task automatic do_layer(input string tag, input int idx, input int base, input int rd,
                            input int wr, input bit poke_start);
        for (int i = 0; i < 20; i++) begin
            if (layer_valid === 1'b1) break;
            tick();
        end
        check({tag, ".valid"}, 32'(layer_valid), 1);
        check({tag, ".idx"},   32'(layer_idx),   idx);
        check({tag, ".base"},  32'(weight_base), base);
        check({tag, ".rd"},    32'(rd_bankset),  rd);
        check({tag, ".wr"},    32'(wr_bankset),  wr);
        tick();
        check({tag, ".run"}, 32'({layer_valid, busy}), 32'b01);
        for (int i = 0; i < 4; i++) begin
            start = poke_start && (i == 1);
            tick();
        end
        start = 1'b0;
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
    endtask

    task automatic kick(input int n, input int mask);
        num_layers = 4'(n);
        tcn_mask   = 8'(mask);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    int d0, h0;

    initial begin
        rst = 1'b1; start = 1'b0; num_layers = '0; tcn_mask = '0;
        layer_ready = 1'b1; layer_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst.flags", 32'({layer_valid, busy, done}), 0);
        check("rst.idx",   32'(layer_idx),   0);
        check("rst.base",  32'(weight_base), 0);
        check("rst.rd",    32'(rd_bankset),  0);
        check("rst.wr",    32'(wr_bankset),  1);

        // Three plain layers: ping-pong 0/1.
        d0 = n_done; h0 = n_hs;
        kick(3, 0);
        do_layer("t1.l0", 0, 0,  0, 1, 0);
        do_layer("t1.l1", 1, 18, 1, 0, 0);
        do_layer("t1.l2", 2, 36, 0, 1, 0);
        check("t1.done", 32'(done), 1);
        tick();
        check("t1.idle", 32'({done, busy}), 0);
        check("t1.ndone", 32'(n_done - d0), 1);
        check("t1.nhs",   32'(n_hs - h0),   3);
        check("t1.hold_base", 32'(weight_base), 36);

        // Layer 1 writes the TCN set; layer 2 reads it and writes set 1 (rd=2 is not 1).
        kick(3, 8'b0000_0010);
        do_layer("t2.l0", 0, 0,  0, 1, 0);
        do_layer("t2.l1", 1, 18, 1, 2, 0);
        do_layer("t2.l2", 2, 36, 2, 1, 0);
        check("t2.done", 32'(done), 1);
        tick();

        // Zero layers: straight to the done pulse, no descriptor.
        d0 = n_done; h0 = n_hs;
        kick(0, 0);
        check("t3.done", 32'({done, layer_valid, busy}), 32'b101);
        tick();
        check("t3.idle", 32'({done, busy}), 0);
        check("t3.ndone", 32'(n_done - d0), 1);
        check("t3.nhs",   32'(n_hs - h0),   0);

        // Back-pressure: descriptor held while ready is low.
        h0 = n_hs;
        layer_ready = 1'b0;
        kick(1, 0);
        for (int i = 0; i < 5; i++) begin
            check("t4.stall", 32'({layer_valid, layer_idx, weight_base, rd_bankset, wr_bankset}),
                  32'({1'b1, 3'd0, 8'd0, 2'd0, 2'd1}));
            tick();
        end
        layer_ready = 1'b1;
        tick();
        check("t4.run", 32'(layer_valid), 0);
        check("t4.nhs", 32'(n_hs - h0), 1);
        repeat (3) tick();
        layer_done = 1'b1; tick(); layer_done = 1'b0;
        check("t4.done", 32'(done), 1);
        tick();

        // Count 9 clamps to 8; a start pulse inside RUN must not disturb anything.
        d0 = n_done; h0 = n_hs;
        kick(9, 0);
        for (int l = 0; l < 8; l++)
            do_layer($sformatf("t5.l%0d", l), l, 18 * l, l % 2, (l + 1) % 2, l == 3);
        check("t5.done", 32'({done, layer_valid}), 32'b10);
        check("t5.lastbase", 32'(weight_base), 126);
        tick();
        repeat (3) tick();
        check("t5.quiet", 32'({layer_valid, busy}), 0);
        check("t5.ndone", 32'(n_done - d0), 1);
        check("t5.nhs",   32'(n_hs - h0),   8);

        // Reset while layer 2 is running, then a fresh run with a TCN first layer.
        kick(3, 0);
        do_layer("t6.l0", 0, 0,  0, 1, 0);
        do_layer("t6.l1", 1, 18, 1, 0, 0);
        check("t6.l2valid", 32'(layer_valid), 1);
        tick();
        check("t6.l2run", 32'({layer_valid, busy}), 32'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6.rstflags", 32'({layer_valid, busy, done}), 0);
        check("t6.rstdesc", 32'({layer_idx, weight_base, rd_bankset, wr_bankset}),
              32'({3'd0, 8'd0, 2'd0, 2'd1}));
        d0 = n_done;
        kick(1, 8'b0000_0001);
        do_layer("t6.new", 0, 0, 0, 2, 0);
        check("t6.done", 32'(done), 1);
        tick();
        check("t6.ndone", 32'(n_done - d0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule
